// File: rtl/mouse_cursor_overlay_if.sv
// -----------------------------------------------------------------------------
// mouse_cursor_overlay_if
// Groups the PS/2 packet stream and the VGA pixel stream that feed the
// cursor overlay.
//   packet_valid  one-cycle strobe, packet_data valid
//   packet_data   [7:0] status, [15:8] dX, [23:16] dY
//   frame_start   one-cycle pulse at start of vertical blank
//   pixel_tick    pixel enable from VGA timing
//   video_on      visible-area flag
//   pixel_x/y     current pixel column/row
//   bg_rgb        background colour for the current pixel
//   rgb           composited colour back towards the VGA output block
// The master drives the streams; the slave (the overlay) returns rgb.
// -----------------------------------------------------------------------------
interface mouse_cursor_overlay_if #(
    parameter int COORD_W = 10,
    parameter int COLOR_W = 12
);
    logic               packet_valid;
    logic [23:0]        packet_data;
    logic               frame_start;
    logic               pixel_tick;
    logic               video_on;
    logic [COORD_W-1:0] pixel_x;
    logic [COORD_W-1:0] pixel_y;
    logic [COLOR_W-1:0] bg_rgb;
    logic [COLOR_W-1:0] rgb;

    modport master (
        output packet_valid, packet_data, frame_start,
        output pixel_tick, video_on, pixel_x, pixel_y, bg_rgb,
        input  rgb
    );

    modport slave (
        input  packet_valid, packet_data, frame_start,
        input  pixel_tick, video_on, pixel_x, pixel_y, bg_rgb,
        output rgb
    );
endinterface

// File: rtl/mouse_cursor_overlay.sv
// -----------------------------------------------------------------------------
// mouse_cursor_overlay
// Tracks an absolute cursor position from decoded PS/2 mouse packets, latches
// it once per frame and composites a square cursor sprite onto the background
// pixel stream.
//   clk           system clock
//   rst_n         asynchronous active-low reset
//   bus           packet and pixel streams (slave side), composited rgb out
//   cursor_x/y    displayed cursor left/top edge
//   buttons       latched {M,R,L}
//   packet_errors saturating count of packets rejected for a bad sync bit
// -----------------------------------------------------------------------------
module mouse_cursor_overlay #(
    parameter int H_RES       = 640,
    parameter int V_RES       = 480,
    parameter int COORD_W     = 10,
    parameter int CURSOR_SIZE = 8,
    parameter int SPEED_SHIFT = 0,
    parameter int COLOR_W     = 12
) (
    input  logic               clk,
    input  logic               rst_n,
    mouse_cursor_overlay_if.slave bus,
    output logic [COORD_W-1:0] cursor_x,
    output logic [COORD_W-1:0] cursor_y,
    output logic [2:0]         buttons,
    output logic [7:0]         packet_errors
);
    localparam int SUM_W = COORD_W + 4;   // signed headroom for position + shifted delta
    localparam int HIT_W = COORD_W + 1;   // hit test width, box end never overflows
    localparam int FIELD = COLOR_W / 3;

    localparam int MAX_X = H_RES - CURSOR_SIZE;
    localparam int MAX_Y = V_RES - CURSOR_SIZE;
    localparam logic [COORD_W-1:0] DEF_X = COORD_W'(MAX_X / 2);
    localparam logic [COORD_W-1:0] DEF_Y = COORD_W'(MAX_Y / 2);
    localparam logic signed [SUM_W-1:0] MAX_X_S = SUM_W'(MAX_X);
    localparam logic signed [SUM_W-1:0] MAX_Y_S = SUM_W'(MAX_Y);

    localparam logic [COLOR_W-1:0] RED   = {{FIELD{1'b1}}, {(2*FIELD){1'b0}}};
    localparam logic [COLOR_W-1:0] GREEN = {{FIELD{1'b0}}, {FIELD{1'b1}}, {FIELD{1'b0}}};
    localparam logic [COLOR_W-1:0] BLUE  = {{(2*FIELD){1'b0}}, {FIELD{1'b1}}};
    localparam logic [COLOR_W-1:0] WHITE = RED | GREEN | BLUE;

    // ------------------------------------------------------------------------
    // Packet decode and position update
    // ------------------------------------------------------------------------
    logic [7:0]               status;
    logic                     sync_ok;
    logic [COORD_W-1:0]       live_x, live_y;
    logic signed [SUM_W-1:0]  dx_ext, dy_ext, sum_x, sum_y;
    logic [COORD_W-1:0]       next_x, next_y;

    assign status  = bus.packet_data[7:0];
    assign sync_ok = status[3];

    function automatic logic [COORD_W-1:0] clamp_coord(
        input logic signed [SUM_W-1:0] v,
        input logic signed [SUM_W-1:0] max_v
    );
        if (v[SUM_W-1])  return '0;
        if (v > max_v)   return max_v[COORD_W-1:0];
        return v[COORD_W-1:0];
    endfunction

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        // 9-bit two's complement {sign, byte}, sign-extended then scaled.
        dx_ext = {{(SUM_W-8){status[4]}}, bus.packet_data[15:8]};
        dy_ext = {{(SUM_W-8){status[5]}}, bus.packet_data[23:16]};
        dx_ext = dx_ext <<< SPEED_SHIFT;
        dy_ext = dy_ext <<< SPEED_SHIFT;
        if (status[6]) dx_ext = '0;
        if (status[7]) dy_ext = '0;

        sum_x = $signed({{(SUM_W-COORD_W){1'b0}}, live_x}) + dx_ext;
        // PS/2 Y counts up-positive, screen rows count downwards.
        sum_y = $signed({{(SUM_W-COORD_W){1'b0}}, live_y}) - dy_ext;

        next_x = clamp_coord(sum_x, MAX_X_S);
        next_y = clamp_coord(sum_y, MAX_Y_S);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values; the display latch relies on this to take the
    // pre-packet live position when frame_start and packet_valid coincide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live_x        <= DEF_X;
            live_y        <= DEF_Y;
            buttons       <= '0;
            packet_errors <= '0;
        end else if (bus.packet_valid) begin
            if (sync_ok) begin
                live_x  <= next_x;
                live_y  <= next_y;
                buttons <= status[2:0];
            end else if (packet_errors != 8'hFF) begin
                packet_errors <= packet_errors + 8'd1;
            end
        end
    end

    // Display copy only moves during vertical blank so the sprite never tears.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cursor_x <= DEF_X;
            cursor_y <= DEF_Y;
        end else if (bus.frame_start) begin
            cursor_x <= live_x;
            cursor_y <= live_y;
        end
    end

    // ------------------------------------------------------------------------
    // Pixel path
    // ------------------------------------------------------------------------
    logic [HIT_W-1:0]   px, py, bx0, by0, bx1, by1;
    logic               in_box, on_border;
    logic [COLOR_W-1:0] cursor_color, pix_next, rgb_q;

    always_comb begin
        px  = {1'b0, bus.pixel_x};
        py  = {1'b0, bus.pixel_y};
        bx0 = {1'b0, cursor_x};
        by0 = {1'b0, cursor_y};
        bx1 = bx0 + HIT_W'(CURSOR_SIZE - 1);
        by1 = by0 + HIT_W'(CURSOR_SIZE - 1);

        in_box    = (px >= bx0) && (px <= bx1) && (py >= by0) && (py <= by1);
        on_border = in_box && ((px == bx0) || (px == bx1) || (py == by0) || (py == by1));

        cursor_color = '0;
        if (buttons == 3'b000) begin
            cursor_color = WHITE;
        end else begin
            if (buttons[0]) cursor_color = cursor_color | RED;
            if (buttons[1]) cursor_color = cursor_color | GREEN;
            if (buttons[2]) cursor_color = cursor_color | BLUE;
        end

        pix_next = bus.bg_rgb;
        if (!bus.video_on)
            pix_next = '0;
        else if (on_border || (in_box && buttons != 3'b000))
            pix_next = cursor_color;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rgb_q <= '0;
        else if (bus.pixel_tick)
            rgb_q <= pix_next;
    end

    assign bus.rgb = rgb_q;

endmodule

// File: tb/tb_mouse_cursor_overlay.sv
// -----------------------------------------------------------------------------
// tb_mouse_cursor_overlay
// Scoreboard bench: a reference model computes expected outputs as stimulus
// is driven, pushes them to a queue, and the queue is drained and compared
// against the DUT one clock later.
// -----------------------------------------------------------------------------
module tb_mouse_cursor_overlay;
    localparam int H_RES       = 640;
    localparam int V_RES       = 480;
    localparam int COORD_W     = 10;
    localparam int CURSOR_SIZE = 8;
    localparam int SPEED_SHIFT = 0;
    localparam int COLOR_W     = 12;
    localparam int MAX_X       = H_RES - CURSOR_SIZE;
    localparam int MAX_Y       = V_RES - CURSOR_SIZE;

    logic               clk;
    logic               rst_n;
    logic [COORD_W-1:0] cursor_x, cursor_y;
    logic [2:0]         buttons;
    logic [7:0]         packet_errors;

    mouse_cursor_overlay_if #(.COORD_W(COORD_W), .COLOR_W(COLOR_W)) bus ();

    mouse_cursor_overlay #(
        .H_RES(H_RES), .V_RES(V_RES), .COORD_W(COORD_W),
        .CURSOR_SIZE(CURSOR_SIZE), .SPEED_SHIFT(SPEED_SHIFT), .COLOR_W(COLOR_W)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus),
        .cursor_x(cursor_x),
        .cursor_y(cursor_y),
        .buttons(buttons),
        .packet_errors(packet_errors)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------------
    // Checking and scoreboard
    // ------------------------------------------------------------------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    typedef enum int {K_RGB, K_CX, K_CY, K_BTN, K_ERR} kind_e;
    typedef struct {
        kind_e       kind;
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];

    task automatic push(input kind_e k, input string tag, input int v);
        exp_t e;
        e.kind = k;
        e.tag  = tag;
        e.val  = 32'(v);
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.kind)
                K_RGB:   check(e.tag, 32'(bus.rgb),       e.val);
                K_CX:    check(e.tag, 32'(cursor_x),      e.val);
                K_CY:    check(e.tag, 32'(cursor_y),      e.val);
                K_BTN:   check(e.tag, 32'(buttons),       e.val);
                default: check(e.tag, 32'(packet_errors), e.val);
            endcase
        end
    endtask

    // ------------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------------
    int m_x, m_y, m_dx, m_dy, m_btn, m_err, m_rgb;

    task automatic model_reset();
        m_x   = MAX_X / 2;
        m_y   = MAX_Y / 2;
        m_dx  = m_x;
        m_dy  = m_y;
        m_btn = 0;
        m_err = 0;
        m_rgb = 0;
    endtask

    function automatic int clampi(input int v, input int hi);
        if (v < 0)  return 0;
        if (v > hi) return hi;
        return v;
    endfunction

    function automatic int model_pixel(input int x, input int y, input bit von, input int bg);
        bit inb, brd;
        int col;
        if (!von) return 0;
        inb = (x >= m_dx) && (x < m_dx + CURSOR_SIZE) && (y >= m_dy) && (y < m_dy + CURSOR_SIZE);
        brd = inb && (x == m_dx || x == m_dx + CURSOR_SIZE - 1 || y == m_dy || y == m_dy + CURSOR_SIZE - 1);
        if (m_btn == 0) col = 'hFFF;
        else col = ((m_btn & 1) != 0 ? 'hF00 : 0) | ((m_btn & 2) != 0 ? 'h0F0 : 0) | ((m_btn & 4) != 0 ? 'h00F : 0);
        if (brd || (inb && m_btn != 0)) return col;
        return bg;
    endfunction

    // ------------------------------------------------------------------------
    // Stimulus tasks (inputs driven on the falling edge, outputs checked on the
    // next falling edge)
    // ------------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        drain();
    endtask

    task automatic send(input logic [7:0] st, input logic [7:0] dx, input logic [7:0] dy, input bit with_frame);
        int ddx, ddy;
        bus.packet_valid = 1'b1;
        bus.packet_data  = {dy, dx, st};
        bus.frame_start  = with_frame;
        if (with_frame) begin
            m_dx = m_x;
            m_dy = m_y;
        end
        if (!st[3]) begin
            if (m_err < 255) m_err++;
        end else begin
            m_btn = int'(st[2:0]);
            ddx = (st[4] ? int'(dx) - 256 : int'(dx)) * (1 << SPEED_SHIFT);
            ddy = (st[5] ? int'(dy) - 256 : int'(dy)) * (1 << SPEED_SHIFT);
            if (!st[6]) m_x = clampi(m_x + ddx, MAX_X);
            if (!st[7]) m_y = clampi(m_y - ddy, MAX_Y);
        end
        tick();
        bus.packet_valid = 1'b0;
        bus.frame_start  = 1'b0;
    endtask

    task automatic frame();
        bus.frame_start = 1'b1;
        m_dx = m_x;
        m_dy = m_y;
        tick();
        bus.frame_start = 1'b0;
    endtask

    // Drives one pixel; the registered output must not change before the edge.
    task automatic pixel(input string tag, input int x, input int y, input bit von,
                         input int bg, input bit en, input int exp);
        bus.pixel_tick = en;
        bus.video_on   = von;
        bus.pixel_x    = COORD_W'(x);
        bus.pixel_y    = COORD_W'(y);
        bus.bg_rgb     = COLOR_W'(bg);
        #1 check({tag, "_pre"}, 32'(bus.rgb), 32'(m_rgb));
        if (en) m_rgb = model_pixel(x, y, von, bg);
        push(K_RGB, tag, exp);
        tick();
        bus.pixel_tick = 1'b0;
    endtask

    task automatic move_to(input int tx, input int ty);
        int dx, dy;
        logic [7:0] st;
        for (int n = 0; n < 16 && (m_x != tx || m_y != ty); n++) begin
            dx = tx - m_x;
            dy = m_y - ty;
            if (dx > 255)  dx = 255;
            if (dx < -256) dx = -256;
            if (dy > 255)  dy = 255;
            if (dy < -256) dy = -256;
            st = 8'h08 | (dx < 0 ? 8'h10 : 8'h00) | (dy < 0 ? 8'h20 : 8'h00);
            send(st, 8'(dx), 8'(dy), 1'b0);
        end
        check("move_to_reached", 32'(m_x * 1024 + m_y), 32'(tx * 1024 + ty));
    endtask

    // ------------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------------
    initial begin
        bus.packet_valid = 1'b0;
        bus.packet_data  = '0;
        bus.frame_start  = 1'b0;
        bus.pixel_tick   = 1'b0;
        bus.video_on     = 1'b0;
        bus.pixel_x      = '0;
        bus.pixel_y      = '0;
        bus.bg_rgb       = '0;
        model_reset();

        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        push(K_RGB, "rst_rgb", 0);
        push(K_BTN, "rst_btn", 0);
        push(K_ERR, "rst_err", 0);
        drain();
        rst_n = 1'b1;

        // Defaults after the first frame.
        push(K_CX, "def_cx", 316);
        push(K_CY, "def_cy", 236);
        frame();

        // Simple move, display only follows at FrameStart.
        push(K_CX, "mv_hold_cx", 316);
        send(8'h08, 8'h05, 8'h03, 1'b0);
        push(K_CX, "mv_cx", 321);
        push(K_CY, "mv_cy", 233);
        frame();

        // Packet coincident with FrameStart shows the pre-packet value.
        push(K_CX, "coinc_cx_old", 321);
        send(8'h08, 8'h02, 8'h00, 1'b1);
        push(K_CX, "coinc_cx_new", 323);
        frame();

        // Left clamp: three -256 moves.
        repeat (3) send(8'h18, 8'h00, 8'h00, 1'b0);
        push(K_CX, "clamp_left", 0);
        frame();

        // Right clamp.
        repeat (6) send(8'h08, 8'h7F, 8'h00, 1'b0);
        push(K_CX, "clamp_right", 632);
        frame();

        // X overflow: X ignores delta, Y moves up 16.
        send(8'h48, 8'h50, 8'h10, 1'b0);
        push(K_CX, "ovf_cx", 632);
        push(K_CY, "ovf_cy", 217);
        frame();

        // Sync error: nothing moves, buttons kept, error counted.
        send(8'h0B, 8'h00, 8'h00, 1'b0);
        push(K_BTN, "sync_btn", 3);
        push(K_ERR, "sync_err1", 1);
        send(8'h00, 8'h20, 8'h20, 1'b0);
        push(K_CX, "sync_cx", 632);
        push(K_CY, "sync_cy", 217);
        frame();
        for (int i = 0; i < 299; i++) begin
            if (i == 298) push(K_ERR, "sync_err_sat", 255);
            send(8'h00, 8'h01, 8'h01, 1'b0);
        end

        // Rendering at (100,50).
        send(8'h08, 8'h00, 8'h00, 1'b0);
        move_to(100, 50);
        push(K_CX, "rnd_cx", 100);
        push(K_CY, "rnd_cy", 50);
        frame();

        bus.video_on = 1'b1;
        pixel("px_corner",   100, 50, 1'b1, 'h123, 1'b1, 'hFFF);
        pixel("px_interior", 103, 53, 1'b1, 'h456, 1'b1, 'h456);
        pixel("px_right_out",108, 50, 1'b1, 'h789, 1'b1, 'h789);
        pixel("px_left_out",  99, 52, 1'b1, 'h321, 1'b1, 'h321);
        pixel("px_far_corner",107, 57, 1'b1, 'h654, 1'b1, 'hFFF);
        pixel("px_hold",     103, 53, 1'b1, 'h456, 1'b0, 'hFFF);
        pixel("px_below_out",104, 58, 1'b1, 'h0AA, 1'b1, 'h0AA);

        send(8'h09, 8'h00, 8'h00, 1'b0);
        pixel("px_l_interior", 103, 53, 1'b1, 'h456, 1'b1, 'hF00);
        send(8'h0B, 8'h00, 8'h00, 1'b0);
        pixel("px_lr_interior",103, 53, 1'b1, 'h456, 1'b1, 'hFF0);
        send(8'h0C, 8'h00, 8'h00, 1'b0);
        pixel("px_m_border",   100, 55, 1'b1, 'h456, 1'b1, 'h00F);
        pixel("px_video_off",  100, 50, 1'b0, 'h456, 1'b1, 'h000);
        pixel("px_on_again",   103, 53, 1'b1, 'h456, 1'b1, 'h00F);

        // Reset mid-frame with a packet strobe present.
        bus.packet_valid = 1'b1;
        bus.packet_data  = {8'h00, 8'h10, 8'h09};
        bus.pixel_tick   = 1'b1;
        rst_n = 1'b0;
        model_reset();
        #1;
        push(K_CX,  "midrst_cx",  316);
        push(K_CY,  "midrst_cy",  236);
        push(K_RGB, "midrst_rgb", 0);
        push(K_BTN, "midrst_btn", 0);
        push(K_ERR, "midrst_err", 0);
        drain();
        @(posedge clk);
        @(negedge clk);
        bus.packet_valid = 1'b0;
        bus.pixel_tick   = 1'b0;
        rst_n = 1'b1;
        push(K_CX,  "postrst_cx",  316);
        push(K_CY,  "postrst_cy",  236);
        push(K_BTN, "postrst_btn", 0);
        frame();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/mouse_cursor_overlay.md
Name: mouse_cursor_overlay

Overview:
- Parametrised successor to the fixed button-to-colour mapping in the controller top level.
- Consumes decoded 3-byte PS/2 mouse packets and keeps an absolute cursor position, clamped to a configurable screen.
- Latches the position once per frame and overlays a square cursor sprite on the background RGB stream feeding the VGA output block.
- Cursor colour and fill follow the button state.

Parameters:
H_RES, 640, visible horizontal pixels
V_RES, 480, visible vertical lines
COORD_W, 10, width of pixel/cursor coordinates
CURSOR_SIZE, 8, cursor side length in pixels (>=3)
SPEED_SHIFT, 0, left shift applied to each delta (0..3)
COLOR_W, 12, RGB width (three equal fields, R high)

Ports:
Clk  in  1  system clock
Reset  in  1  asynchronous, active-low reset
PacketValid  in  1  one-cycle strobe, PacketData valid
PacketData  in  24  [7:0] status (b0 L, b1 R, b2 M, b3 sync=1, b4 Xsign, b5 Ysign, b6 Xovf, b7 Yovf), [15:8] dX, [23:16] dY
FrameStart  in  1  one-cycle pulse at start of vertical blank
PixelTick  in  1  pixel enable from VGA timing
VideoOn  in  1  visible-area flag
PixelX  in  COORD_W  current pixel column
PixelY  in  COORD_W  current pixel row
BgRGB  in  COLOR_W  background colour for current pixel
RGB  out  COLOR_W  composited colour
CursorX  out  COORD_W  displayed cursor left edge
CursorY  out  COORD_W  displayed cursor top edge
Buttons  out  3  latched {M,R,L}
PacketErrors  out  8  saturating count of rejected packets

Behaviour:
- Reset (async assert, sync release):
  - Live and displayed positions = ((H_RES-CURSOR_SIZE)/2, (V_RES-CURSOR_SIZE)/2).
  - Buttons=0, PacketErrors=0, RGB=0.
- Packet accept, on the PacketValid cycle:
  - If status b3=0: packet dropped; PacketErrors += 1, saturating at 255; nothing else changes.
  - Otherwise Buttons <= status[2:0] in the same cycle.
  - Deltas are 9-bit two's complement {sign, byte}, shifted left by SPEED_SHIFT, added in signed COORD_W+4 arithmetic.
  - X: live_x + dX. Y: live_y - dY (PS/2 Y is up-positive).
  - An axis whose overflow bit is set ignores its delta; the other axis still updates.
- Clamp:
  - X to [0, H_RES-CURSOR_SIZE]; Y to [0, V_RES-CURSOR_SIZE].
  - Negative intermediate -> 0; above max -> max. No wrap-around.
- Live position becomes visible 1 cycle after PacketValid.
- Display latch:
  - CursorX/CursorY <= live position on FrameStart, so the cursor never tears mid-frame.
  - If FrameStart and PacketValid coincide, the display takes the pre-packet live value. The new packet is shown at the next FrameStart.
- Pixel path, registered with 1 Clk latency, updated only on cycles with PixelTick=1, otherwise held:
  - VideoOn=0 -> RGB=0.
  - Pixel inside the box [CursorX, CursorX+CURSOR_SIZE-1] x [CursorY, CursorY+CURSOR_SIZE-1]:
    - Border pixel (on the box edge) -> cursor colour.
    - Interior pixel -> cursor colour if any button is held, else BgRGB (hollow cursor).
  - Otherwise -> BgRGB.
- Cursor colour:
  - L only: red (R field all ones).
  - R only: green.
  - M only: blue.
  - Several buttons: OR of the individual colours.
  - None: white.
- Hit test uses unsigned compares in COORD_W+1 bits; no overflow, because clamping keeps the box on-screen.

Test Plan:
- Reset, then one FrameStart -> CursorX=316, CursorY=236 (defaults), RGB=0, PacketErrors=0.
- Packet status=0x08, dX=0x05, dY=0x03, then FrameStart -> CursorX=321, CursorY=233. Packet issued with FrameStart in the same cycle -> display changes only at the following FrameStart.
- Boundary clamp: three packets with dX=-256 (status 0x18, byte 0x00) -> CursorX=0, never wraps. Positive packets up to the right edge -> CursorX=632. Overflow packet status 0x48 with dY=0x10 -> X unchanged, Y moves up 16.
- Sync error: packet with status 0x00 -> position and Buttons unchanged, PacketErrors=1. Bench sends 300 such packets -> PacketErrors=255.
- Rendering, cursor at (100,50), no buttons:
  - Pixel (100,50) -> RGB=0xFFF.
  - Pixel (103,53) -> BgRGB.
  - Pixel (108,50) -> BgRGB.
  - With L held, pixel (103,53) -> 0xF00.
  - VideoOn=0 -> 0x000.
  - RGB lags PixelTick by exactly 1 Clk.
- Reset asserted mid-frame with a packet strobe present -> all outputs return to reset values immediately; the packet is lost.
